// File: rtl/dct_pkg.sv
// dct_pkg: shared types, fp32 DCT-II basis table and fixed-point conversion for the coefficient sequencer
package dct_pkg;
  localparam int N = 8;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  localparam logic [31:0] S  = 32'h8000_0000;
  localparam logic [31:0] C0 = 32'h3eb504f3;
  localparam logic [31:0] C1 = 32'h3efb14be;
  localparam logic [31:0] C2 = 32'h3eec835e;
  localparam logic [31:0] C3 = 32'h3ed4db31;
  localparam logic [31:0] C5 = 32'h3e8e39da;
  localparam logic [31:0] C6 = 32'h3e43ef15;
  localparam logic [31:0] C7 = 32'h3dc7c5c2;
  // Row k, column n holds c_k*cos((2n+1)k*pi/16); cos(4pi/16)/2 equals 1/sqrt(8), hence C0 in row 4
  localparam logic [31:0] FP_TAB [64] = '{
    C0,   C0,   C0,   C0,   C0,   C0,   C0,   C0,
    C1,   C3,   C5,   C7,   C7|S, C5|S, C3|S, C1|S,
    C2,   C6,   C6|S, C2|S, C2|S, C6|S, C6,   C2,
    C3,   C7|S, C1|S, C5|S, C5,   C1,   C7,   C3|S,
    C0,   C0|S, C0|S, C0,   C0,   C0|S, C0|S, C0,
    C5,   C1|S, C7,   C3,   C3|S, C7|S, C1,   C5|S,
    C6,   C2|S, C2,   C6|S, C6|S, C2,   C2|S, C6,
    C7,   C5|S, C3,   C1|S, C1,   C3|S, C5,   C7|S
  };
  function automatic logic [63:0] fp32_to_fix(input logic [31:0] bits, input int frac_w, input int data_w);
    logic [63:0] m, mag, r;
    int s;
    m = {40'd0, 1'b1, bits[22:0]};
    s = int'(bits[30:23]) - 150 + frac_w;
    if (bits[30:23] == 8'd0) mag = '0;
    else if (s >= 0) mag = m << s;
    else mag = (m + (64'd1 << (-s - 1))) >> (-s);
    r = bits[31] ? -mag : mag;
    return data_w >= 64 ? r : r & ((64'd1 << data_w) - 64'd1);
  endfunction
endpackage

// File: rtl/dct_coef_rom.sv
// dct_coef_rom: combinational lookup of two basis-matrix rows in fp32 or fixed-point form
module dct_coef_rom import dct_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int FMT    = 0,
  parameter int FRAC_W = 14
) (
  input  logic [2:0]        row_sel,
  input  logic [2:0]        col_sel,
  output logic [DATA_W-1:0] row_vec [7:0],
  output logic [DATA_W-1:0] col_vec [7:0]
);
  logic [DATA_W-1:0] rom [64];
  for (genvar i = 0; i < 64; i++) begin : g_rom
    localparam logic [63:0] E = (FMT == 1) ? fp32_to_fix(FP_TAB[i], FRAC_W, DATA_W) : {32'd0, FP_TAB[i]};
    assign rom[i] = E[DATA_W-1:0];
  end
  for (genvar n = 0; n < N; n++) begin : g_vec
    assign row_vec[n] = rom[{row_sel, 3'(n)}];
    assign col_vec[n] = rom[{col_sel, 3'(n)}];
  end
endmodule

// File: rtl/dct_coef_seq.sv
// dct_coef_seq: sweeps (row, col) pairs of the DCT basis and streams registered vectors over valid/ready
module dct_coef_seq import dct_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int FMT    = 0,
  parameter int FRAC_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic              abort,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        out_row_idx,
  output logic [2:0]        out_col_idx,
  output logic              out_last,
  output logic [DATA_W-1:0] row_vec [7:0],
  output logic [DATA_W-1:0] col_vec [7:0]
);
  if ((FMT == 0 && DATA_W != 32) || (FMT == 1 && DATA_W < FRAC_W + 2)) begin : g_bad
    $error("dct_coef_seq: illegal DATA_W/FMT/FRAC_W combination");
  end
  state_t state;
  logic md;
  logic [5:0] cnt;
  logic [2:0] row_sel, col_sel;
  logic fin, ld;
  logic [DATA_W-1:0] rv [7:0];
  logic [DATA_W-1:0] cv [7:0];
  assign row_sel = md ? cnt[2:0] : cnt[5:3];
  assign col_sel = cnt[2:0];
  assign fin = cnt == {md ? 3'd0 : 3'd7, 3'd7};
  // The start edge itself loads pair 0 (selects are 0 for either mode) so beat 0 is valid one cycle after start
  assign ld = (state == IDLE && start) || (state == RUN && (!out_valid || out_ready));
  dct_coef_rom #(.DATA_W(DATA_W), .FMT(FMT), .FRAC_W(FRAC_W)) u_rom (
    .row_sel(row_sel),
    .col_sel(col_sel),
    .row_vec(rv),
    .col_vec(cv)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      md <= 1'b0;
      cnt <= '0;
      busy <= 1'b0;
      out_valid <= 1'b0;
      out_last <= 1'b0;
      out_row_idx <= '0;
      out_col_idx <= '0;
      row_vec <= '{default: '0};
      col_vec <= '{default: '0};
    end else if (abort) begin
      state <= IDLE;
      cnt <= '0;
      busy <= 1'b0;
      out_valid <= 1'b0;
      out_last <= 1'b0;
    end else begin
      if (ld) begin
        row_vec <= rv;
        col_vec <= cv;
        out_row_idx <= row_sel;
        out_col_idx <= col_sel;
        out_valid <= 1'b1;
        out_last <= fin;
        cnt <= fin ? '0 : cnt + 6'd1;
      end else if (state == DRAIN && out_ready) begin
        out_valid <= 1'b0;
        out_last <= 1'b0;
      end
      case (state)
        IDLE: if (start) begin
          state <= RUN;
          md <= mode;
          busy <= 1'b1;
        end
        RUN: if (ld && fin) state <= DRAIN;
        DRAIN: if (out_ready) begin
          state <= IDLE;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dct_coef_seq.sv
// tb_dct_coef_seq: table-driven sweeps with a beat scoreboard checking fp32 and fixed-point instances
module tb_dct_coef_seq;
  logic clk, rst, start, mode, abort, out_ready;
  logic busy0, v0, last0, busy1, v1, last1;
  logic [2:0] r0, c0, r1, c1;
  logic [31:0] row0 [7:0];
  logic [31:0] col0 [7:0];
  logic [15:0] row1 [7:0];
  logic [15:0] col1 [7:0];
  typedef struct {logic [2:0] r; logic [2:0] c; logic last;} beat_t;
  typedef struct {logic m; logic rnd; int beats; int cycles;} vec_t;
  beat_t sb[$];
  int pass = 0, total = 0, hs = 0;
  logic [31:0] exp_fp [8][8];
  logic [15:0] exp_fx [8][8];
  real magr [7] = '{0.353553, 0.490393, 0.415735, 0.277785, 0.097545, 0.461940, 0.191342};
  logic [31:0] magb [7] = '{32'h3eb504f3, 32'h3efb14be, 32'h3ed4db31, 32'h3e8e39da, 32'h3dc7c5c2, 32'h3eec835e, 32'h3e43ef15};

  dct_coef_seq #(.DATA_W(32), .FMT(0), .FRAC_W(14)) dut0 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .abort(abort), .busy(busy0),
    .out_valid(v0), .out_ready(out_ready), .out_row_idx(r0), .out_col_idx(c0),
    .out_last(last0), .row_vec(row0), .col_vec(col0));
  dct_coef_seq #(.DATA_W(16), .FMT(1), .FRAC_W(14)) dut1 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .abort(abort), .busy(busy1),
    .out_valid(v1), .out_ready(out_ready), .out_row_idx(r1), .out_col_idx(c1),
    .out_last(last1), .row_vec(row1), .col_vec(col1));

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else pass++;
  endtask

  function automatic real coefr(input int k, input int n);
    real c;
    c = (k == 0) ? 1.0 / $sqrt(8.0) : 0.5;
    return c * $cos(real'((2 * n + 1) * k) * 3.14159265358979 / 16.0);
  endfunction

  always @(negedge clk) begin
    if (!rst && v0 && out_ready) begin
      hs++;
      if (sb.size() == 0) begin
        total++;
        $display("FAIL sb_underflow: got beat (%0d,%0d) expected none", r0, c0);
      end else begin
        beat_t e;
        e = sb.pop_front();
        chk("row_idx", r0, e.r);
        chk("col_idx", c0, e.c);
        chk("last", last0, e.last);
        chk("fix_valid", v1, 1);
        chk("fix_idx", {r1, c1, last1}, {e.r, e.c, e.last});
        for (int n = 0; n < 8; n++) begin
          chk("fp_row", row0[n], exp_fp[e.r][n]);
          chk("fp_col", col0[n], exp_fp[e.c][n]);
          chk("fx_row", row1[n], exp_fx[e.r][n]);
          chk("fx_col", col1[n], exp_fx[e.c][n]);
        end
        if (e.r == 0 && e.c == 0) chk("spot_b0", row0[0], 32'h3eb504f3);
        if (e.r == 1 && e.c == 1) begin
          chk("spot_b9_row", row0[0], 32'h3efb14be);
          chk("spot_b9_col", col0[7], 32'hbefb14be);
        end
        if (e.r == 7 && e.c == 7) begin
          chk("spot_b63_row", row0[7], 32'hbdc7c5c2);
          chk("spot_b63_last", last0, 1);
        end
        if (e.r == 0) chk("spot_fx_r0", row1[3], 16'h16A1);
        if (e.r == 1 && e.c == 0) begin
          chk("spot_fx_r1c0", row1[0], 16'h1F63);
          chk("spot_fx_r1c7", row1[7], 16'hE09D);
        end
      end
    end
  end

  task automatic start_sweep(input logic m, input int n);
    for (int b = 0; b < n; b++)
      sb.push_back('{m ? 3'(b) : 3'(b / 8), m ? 3'(b) : 3'(b % 8), b == n - 1});
    start = 1;
    mode = m;
    @(posedge clk) #1;
    start = 0;
    chk("first_valid", v0, 1);
  endtask

  task automatic wait_done(input int base, input int n, input logic rnd, output int cyc);
    cyc = 0;
    while (busy0 && cyc < 2000) begin
      if (rnd) begin
        out_ready = 1'($urandom_range(0, 1));
        start = 1'($urandom_range(0, 1));
        mode = 1'($urandom_range(0, 1));
      end
      @(posedge clk) #1;
      cyc++;
    end
    start = 0;
    out_ready = 1;
    chk("busy_done", busy0, 0);
    chk("hs_count", hs - base, n);
    chk("sb_empty", sb.size(), 0);
  endtask

  task automatic wait_idx(input logic [2:0] r, input logic [2:0] c);
    int k;
    k = 0;
    while (!(v0 && r0 == r && c0 == c) && k < 200) begin
      @(posedge clk) #1;
      k++;
    end
    chk("wait_idx", k < 200, 1);
  endtask

  task automatic run_sweep(input vec_t t);
    int base, cyc;
    base = hs;
    start_sweep(t.m, t.beats);
    wait_done(base, t.beats, t.rnd, cyc);
    if (t.cycles >= 0) chk("sweep_cycles", cyc, t.cycles);
  endtask

  initial begin
    vec_t tab [4];
    int base, cyc;
    logic [2:0] sr, sc;
    logic [31:0] srow [7:0];
    logic [31:0] scol [7:0];
    for (int k = 0; k < 8; k++)
      for (int n = 0; n < 8; n++) begin
        real v, a, x, bd, d;
        int j, r;
        v = coefr(k, n);
        a = v < 0 ? -v : v;
        j = 0;
        bd = 10.0;
        for (int q = 0; q < 7; q++) begin
          d = a - magr[q];
          d = d < 0 ? -d : d;
          if (d < bd) begin bd = d; j = q; end
        end
        exp_fp[k][n] = (v < 0 ? 32'h8000_0000 : 32'h0) | magb[j];
        x = v * 16384.0;
        r = x >= 0 ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
        exp_fx[k][n] = 16'(r);
      end
    tab[0] = '{1'b0, 1'b0, 64, 64};
    tab[1] = '{1'b1, 1'b0, 8, 8};
    tab[2] = '{1'b0, 1'b1, 64, -1};
    tab[3] = '{1'b1, 1'b1, 8, -1};
    rst = 1; start = 0; mode = 0; abort = 0; out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctl", {busy0, v0, last0, r0, c0}, 0);
    chk("rst_vec", {row0[0], col0[7], row1[4], col1[0]}, 0);
    rst = 0;
    @(posedge clk) #1;
    chk("idle_after_rst", {busy0, v0}, 0);
    for (int i = 0; i < 4; i++) run_sweep(tab[i]);

    base = hs;
    start_sweep(1'b0, 64);
    wait_idx(3'd0, 3'd5);
    out_ready = 0;
    sr = r0; sc = c0; srow = row0; scol = col0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk) #1;
      chk("stall_idx", {v0, r0, c0}, {1'b1, sr, sc});
      for (int n = 0; n < 8; n++) chk("stall_vec", {row0[n], col0[n]}, {srow[n], scol[n]});
    end
    out_ready = 1;
    @(posedge clk) #1;
    chk("after_stall", {v0, r0, c0}, {1'b1, 3'd0, 3'd6});
    wait_done(base, 64, 1'b0, cyc);

    base = hs;
    start_sweep(1'b0, 64);
    wait_idx(3'd2, 3'd4);
    abort = 1;
    start = 1;
    @(posedge clk) #1;
    abort = 0;
    start = 0;
    chk("abort_ctl", {v0, busy0, last0, v1, busy1}, 0);
    chk("abort_idx", {r0, c0}, {3'd2, 3'd4});
    chk("abort_vec", row0[5], exp_fp[2][5]);
    chk("abort_hs", hs - base, 21);
    sb.delete();
    repeat (2) @(posedge clk) #1;
    chk("abort_idle", {v0, busy0}, 0);
    run_sweep(tab[0]);

    start_sweep(1'b0, 64);
    wait_idx(3'd3, 3'd6);
    rst = 1;
    #1;
    chk("arst_ctl", {busy0, v0, last0, r0, c0, busy1, v1}, 0);
    for (int n = 0; n < 8; n++) chk("arst_vec", {row0[n], col0[n], row1[n], col1[n]}, 0);
    sb.delete();
    @(posedge clk) #1;
    rst = 0;
    @(posedge clk) #1;
    run_sweep(tab[0]);
    run_sweep(tab[1]);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/dct_coef_seq.md
Name: dct_coef_seq

Overview:
- Parametrised, sequenced successor to the combinational DCT coefficient ROM.
- Holds the 8x8 DCT-II basis matrix A as either IEEE-754 fp32 or signed fixed-point, selected at elaboration.
- Autonomously sweeps (row_sel, col_sel) pairs and streams registered row/column vectors over a valid/ready interface to the DCT MAC array.
- Supports stall, abort, a full 64-pair sweep for A·X·A^T, and an 8-pair diagonal sweep.

Parameters:
- DATA_W, 32, coefficient width; must be 32 when FMT=0, and at least FRAC_W+2 when FMT=1.
- FMT, 0, coefficient format: 0 = fp32 bit patterns; 1 = two's-complement fixed-point.
- FRAC_W, 14, fractional bits when FMT=1; ignored when FMT=0.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  sweep request, sampled in IDLE only.
- mode  in  1  sampled with start: 0 = full 64-pair sweep; 1 = diagonal 8-pair sweep.
- abort  in  1  synchronous sweep cancel.
- busy  out  1  high while not IDLE.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accept.
- out_row_idx  out  3  row_sel of the current beat.
- out_col_idx  out  3  col_sel of the current beat.
- out_last  out  1  final beat of the sweep.
- row_vec  out  DATA_W x 8 (unpacked [7:0])  A[out_row_idx][0..7].
- col_vec  out  DATA_W x 8 (unpacked [7:0])  A[out_col_idx][0..7].

Behaviour:
- Reset (async, rst=1):
  - State IDLE; counters 0.
  - busy=0, out_valid=0, out_last=0.
  - out_row_idx=0, out_col_idx=0.
  - row_vec and col_vec all zero.
- States:
  - IDLE -> RUN on start=1 and abort=0; mode is latched at this edge.
  - RUN -> DRAIN when the final pair is loaded into the output register.
  - DRAIN -> IDLE when the final beat handshakes.
  - Any state -> IDLE on abort=1.
- Pair order:
  - mode 0: row-major, row outer 0..7, col inner 0..7; 64 beats.
  - mode 1: (k,k) for k=0..7; 8 beats.
- Load condition: load_en = RUN & (!out_valid | out_ready).
  - On load_en the ROM vectors for the current counter go into the output register, out_valid=1, and the counter advances.
- Latency: first beat is valid on the cycle after start. A back-to-back sweep with out_ready held high gives one beat per cycle.
- Stall: while out_valid=1 and out_ready=0, every output holds stable and the counter does not advance.
- Handshake completion: out_valid falls only after the handshake of the last beat, or on abort.
- out_last is 1 exactly on the final beat: (7,7) in both modes.
- Abort:
  - Next cycle: IDLE, out_valid=0, out_last=0.
  - Vectors and indices keep their last values.
  - Abort wins over a simultaneous start.
  - A start in the same cycle as the final handshake is ignored, because the state is not yet IDLE.
- start or mode changes while busy have no effect.
- Reset mid-sweep returns to the reset values immediately; no partial state survives.
- FMT=0: entries are the fp32 constants below. Sign is applied per the DCT-II sign pattern A[k][n] = c_k·cos((2n+1)kπ/16).
  - 0.353553 = 0x3eb504f3
  - 0.490393 = 0x3efb14be
  - 0.415735 = 0x3ed4db31
  - 0.277785 = 0x3e8e39da
  - 0.097545 = 0x3dc7c5c2
  - 0.461940 = 0x3eec835e
  - 0.191342 = 0x3e43ef15
- FMT=1: each entry is round-half-away-from-zero of c·2^FRAC_W, sign-extended to DATA_W, negatives in two's complement.
  - Conversion happens at elaboration via a constant function applied to the fp32 table (integer exponent/mantissa shift). There is no runtime arithmetic.
- Illegal parameter combinations (FMT=0 with DATA_W!=32; FMT=1 with DATA_W<FRAC_W+2) are elaboration errors via $error.

Decomposition:
- Package dct_pkg holds:
  - the 64-entry fp32 table;
  - state enum IDLE/RUN/DRAIN;
  - localparam N=8;
  - constant function fp32_to_fix(bits, frac_w, data_w).
- Sub-module dct_coef_rom (parametrised by DATA_W, FMT, FRAC_W) is purely combinational: two 3-bit selects produce two 8-entry vectors. dct_coef_seq wraps it with the counter, FSM and output register.

Test Plan:
- FMT=0, mode 0, out_ready=1, start pulse:
  - beat 0 arrives the next cycle with (0,0), row_vec[0]=0x3eb504f3;
  - beat 9 is (1,1) with row_vec[0]=0x3efb14be and col_vec[7]=0xbefb14be;
  - beat 63 is (7,7) with row_vec[7]=0xbdc7c5c2 and out_last=1;
  - busy deasserts the cycle after that handshake.
- Stall: drop out_ready at beat 5 (0,5) for 3 cycles -> outputs are bit-stable, and beat 6 (0,6) follows one cycle after out_ready rises; the total handshake count is 64.
- mode 1 -> 8 beats (0,0)..(7,7), row_vec equals col_vec on every beat, out_last only on the 8th beat.
- abort at beat 20 (together with start) -> out_valid=0 and busy=0 the next cycle. A start 2 cycles later restarts cleanly at (0,0).
- FMT=1, DATA_W=16, FRAC_W=14, mode 0:
  - row 0 entries are 0x16A1 (5793);
  - row 1 col 0 is 0x1F63 (8035);
  - row 1 col 7 is 0xE09D (-8035).
- Assert rst mid-sweep at beat 30 -> all outputs reach reset values asynchronously; after release, a new start gives beat 0 at (0,0).
